mdio_frame: RTL and testbench

- Clause 22 MDIO management-frame slave. Samples the external MDC/MDIO pins and decodes preamble, start, opcode, PHY address and register address.
- Turns each frame addressed to this PHY into exactly one Wishbone transaction on the MDIO register file. For reads, drives turnaround and read data back onto MDIO.
- Sits between the board-level MDIO pad (tristate buffer outside this block) and the register file.

---
 rtl/mdio_frame_pkg.sv | 15 +
 rtl/mdio_sync.sv | 28 ++
 rtl/mdio_frame.sv | 181 ++++++++++++++++++
 tb/tb_mdio_frame.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_frame_pkg.sv
// Shared MDIO frame constants and FSM state type.
package mdio_frame_pkg;
   typedef enum logic [2:0] {
      S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA
   } state_t;

   localparam logic [1:0] MDIO_ST       = 2'b01;
   localparam logic [1:0] MDIO_OP_READ  = 2'b10;
   localparam logic [1:0] MDIO_OP_WRITE = 2'b01;

   localparam int PHYAD_W = 5;
   localparam int REGAD_W = 5;
   localparam int TA_W    = 2;
   localparam int DATA_W  = 16;
endpackage

// File: rtl/mdio_sync.sv
// Two-flop synchronisers for MDC/MDIO and MDC rising-edge detect.
module mdio_sync (
   input  logic clk,
   input  logic rst,
   input  logic mdc,
   input  logic mdio,
   output logic mdc_rise,
   output logic mdio_s
);
   logic [1:0] mdc_ff;
   logic [1:0] mdio_ff;
   logic       mdc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mdc_ff  <= 2'b00;
         mdio_ff <= 2'b00;
         mdc_q   <= 1'b0;
      end else begin
         mdc_ff  <= {mdc_ff[0], mdc};
         mdio_ff <= {mdio_ff[0], mdio};
         mdc_q   <= mdc_ff[1];
      end
   end

   assign mdc_rise = mdc_ff[1] & ~mdc_q;
   assign mdio_s   = mdio_ff[1];
endmodule

// File: rtl/mdio_frame.sv
// Clause 22 MDIO slave: frame decode to one Wishbone access per frame.
module mdio_frame
   import mdio_frame_pkg::*;
#(
   parameter logic [4:0] PHY_ADDR      = 5'd0,
   parameter int         PREAMBLE_BITS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mdc,
   input  logic              mdio,
   output logic              mdo,
   output logic              mdo_oe,
   output logic              cyc,
   output logic              stb,
   output logic              we,
   output logic [4:0]        addr,
   output logic [DATA_W-1:0] data_write,
   input  logic              ack,
   input  logic              err,
   input  logic [DATA_W-1:0] data_read
);
   localparam int CW = $clog2(PREAMBLE_BITS + 1);

   logic              rise;
   logic              bit_s;
   state_t            state;
   state_t            state_nx;
   logic [CW-1:0]     ones;
   logic [3:0]        cnt;
   logic              op_hi;
   logic [3:0]        phy;
   logic              is_read;
   logic              match;
   logic              abort;
   logic              cap;
   logic              last;
   logic [DATA_W-1:0] sreg;

   mdio_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .mdc      (mdc),
      .mdio     (mdio),
      .mdc_rise (rise),
      .mdio_s   (bit_s)
   );

   always_comb begin
      last = 1'b1;
      unique case (state)
         S_OP:    last = (cnt == 4'd1);
         S_PHY:   last = (cnt == 4'(PHYAD_W - 1));
         S_REG:   last = (cnt == 4'(REGAD_W - 1));
         S_TA:    last = (cnt == 4'(TA_W - 1));
         S_DATA:  last = (cnt == 4'(DATA_W - 1));
         default: last = 1'b1;
      endcase
   end

   always_comb begin
      state_nx = state;
      if (rise) begin
         unique case (state)
            S_PRE:
               if (!bit_s && ones == CW'(PREAMBLE_BITS))
                  state_nx = S_ST;
            S_ST:
               state_nx = ({1'b0, bit_s} == MDIO_ST) ? S_OP : S_PRE;
            S_OP:
               if (last)
                  state_nx = ({op_hi, bit_s} == MDIO_OP_READ ||
                              {op_hi, bit_s} == MDIO_OP_WRITE)
                             ? S_PHY : S_PRE;
            S_PHY:   if (last) state_nx = S_REG;
            S_REG:   if (last) state_nx = S_TA;
            S_TA:    if (last) state_nx = S_DATA;
            S_DATA:  if (last) state_nx = S_PRE;
            default: state_nx = S_PRE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_PRE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ones       <= '0;
         cnt        <= 4'd0;
         op_hi      <= 1'b0;
         phy        <= 4'd0;
         is_read    <= 1'b0;
         match      <= 1'b0;
         abort      <= 1'b0;
         cap        <= 1'b0;
         sreg       <= '0;
         mdo        <= 1'b0;
         mdo_oe     <= 1'b0;
         cyc        <= 1'b0;
         stb        <= 1'b0;
         we         <= 1'b0;
         addr       <= 5'd0;
         data_write <= '0;
      end else begin
         // read data is registered by the slave one clk after ack
         cap <= cyc & ack & ~we;
         if (cap) sreg <= data_read;
         if (cyc && (ack || err)) begin
            cyc <= 1'b0;
            stb <= 1'b0;
            we  <= 1'b0;
            if (err && !we) abort <= 1'b1;
         end
         if (rise) begin
            cnt <= last ? 4'd0 : cnt + 4'd1;
            unique case (state)
               S_PRE:
                  if (!bit_s) ones <= '0;
                  else if (ones != CW'(PREAMBLE_BITS)) ones <= ones + 1'b1;
               S_OP: begin
                  op_hi <= bit_s;
                  if (last) is_read <= ({op_hi, bit_s} == MDIO_OP_READ);
               end
               S_PHY: begin
                  phy <= {phy[2:0], bit_s};
                  if (last) begin
                     match <= ({phy, bit_s} == PHY_ADDR);
                     abort <= 1'b0;
                  end
               end
               S_REG: begin
                  addr <= {addr[3:0], bit_s};
                  if (last && match && is_read) begin
                     cyc <= 1'b1;
                     stb <= 1'b1;
                     we  <= 1'b0;
                  end
               end
               S_TA:
                  if (cnt == 4'd0) begin
                     if (is_read && match) begin
                        // a slave still silent at TA1 is treated as an error
                        if (abort || (cyc && !ack)) begin
                           abort <= 1'b1;
                           cyc   <= 1'b0;
                           stb   <= 1'b0;
                        end else begin
                           mdo_oe <= 1'b1;
                           mdo    <= 1'b0;
                        end
                     end
                  end else if (mdo_oe) begin
                     mdo  <= sreg[DATA_W-1];
                     sreg <= sreg << 1;
                  end
               S_DATA:
                  if (is_read) begin
                     if (last) begin
                        mdo_oe <= 1'b0;
                        mdo    <= 1'b0;
                     end else if (mdo_oe) begin
                        mdo  <= sreg[DATA_W-1];
                        sreg <= sreg << 1;
                     end
                  end else begin
                     data_write <= {data_write[DATA_W-2:0], bit_s};
                     if (last && match) begin
                        cyc <= 1'b1;
                        stb <= 1'b1;
                        we  <= 1'b1;
                     end
                  end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mdio_frame.sv
// Directed bench: MDIO station driver, Wishbone slave model, pad model.
module tb_mdio_frame;
   localparam logic [4:0] PA = 5'h0B;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mdc = 1'b1;
   logic        st_en = 1'b0;
   logic        st_val = 1'b1;
   logic        pin;
   logic        mdo, mdo_oe, cyc, stb, we;
   logic [4:0]  addr;
   logic [15:0] data_write;
   logic        ack = 1'b0;
   logic        err = 1'b0;
   logic [15:0] data_read = 16'hDEAD;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] rd_val = 16'h0000;
   logic        slv_err = 1'b0;
   int          wait_c = 0;
   int          wb_count = 0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_addr = 5'd0;
   logic [15:0] wb_dw = 16'd0;
   logic        oe_seen = 1'b0;
   logic        cyc_seen = 1'b0;
   logic        err_then_cyc = 1'b1;

   always #5 clk = ~clk;

   // pad with pull-up: slave, station, or float-high
   assign pin = mdo_oe ? mdo : (st_en ? st_val : 1'b1);

   mdio_frame #(.PHY_ADDR(PA), .PREAMBLE_BITS(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .mdc        (mdc),
      .mdio       (pin),
      .mdo        (mdo),
      .mdo_oe     (mdo_oe),
      .cyc        (cyc),
      .stb        (stb),
      .we         (we),
      .addr       (addr),
      .data_write (data_write),
      .ack        (ack),
      .err        (err),
      .data_read  (data_read)
   );

   always @(posedge clk) begin
      if (mdo_oe) oe_seen = 1'b1;
      if (cyc) cyc_seen = 1'b1;
   end

   always @(negedge clk) begin
      data_read = ack ? rd_val : 16'hDEAD;
      if (err) err_then_cyc = cyc;
      if (ack || err) begin
         ack = 1'b0;
         err = 1'b0;
      end else if (cyc && stb) begin
         if (wait_c == 2) begin
            wait_c = 0;
            if (slv_err) err = 1'b1;
            else ack = 1'b1;
            wb_count++;
            wb_we   = we;
            wb_addr = addr;
            wb_dw   = data_write;
         end else wait_c++;
      end else wait_c = 0;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mbit(input logic en, input logic v, output logic s);
      mdc = 1'b0;
      st_en = en;
      st_val = v;
      repeat (8) @(posedge clk);
      #1 s = pin;
      mdc = 1'b1;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic frame(input int pre, input logic rd,
                        input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd, input int rst_at,
                        output logic [15:0] rdat, output logic ta2,
                        output logic ta2_oe);
      logic s;
      logic [15:0] hdr;
      rdat = 16'h0;
      ta2 = 1'b1;
      ta2_oe = 1'b0;
      hdr = {2'b01, (rd ? 2'b10 : 2'b01), pa, ra, 2'b00};
      for (int i = 0; i < pre; i++) mbit(1'b1, 1'b1, s);
      for (int i = 15; i >= 2; i--) mbit(1'b1, hdr[i], s);
      if (rd) begin
         mbit(1'b0, 1'b0, s);
         ta2_oe = mdo_oe;
         mbit(1'b0, 1'b0, ta2);
         for (int i = 15; i >= 0; i--) begin
            if (15 - i == rst_at) begin
               @(negedge clk);
               rst = 1'b1;
               return;
            end
            mbit(1'b0, 1'b0, s);
            rdat[i] = s;
         end
      end else begin
         mbit(1'b1, 1'b1, s);
         mbit(1'b1, 1'b0, s);
         for (int i = 15; i >= 0; i--) mbit(1'b1, wd[i], s);
      end
      st_en = 1'b0;
      repeat (10) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] rdat;
      logic        ta2, ta2_oe;
      int          base;

      repeat (4) @(posedge clk);
      #1;
      chk("rst_mdo", {31'd0, mdo}, 32'd0);
      chk("rst_oe", {31'd0, mdo_oe}, 32'd0);
      chk("rst_wb", {29'd0, cyc, stb, we}, 32'd0);
      chk("rst_addr", {27'd0, addr}, 32'd0);
      chk("rst_dw", {16'd0, data_write}, 32'd0);
      rst = 1'b0;
      repeat (4) @(posedge clk);

      // 1: basic read
      rd_val = 16'h7809;
      base = wb_count;
      frame(32, 1'b1, PA, 5'd1, 16'h0, -1, rdat, ta2, ta2_oe);
      chk("t1_rdata", {16'd0, rdat}, 32'h7809);
      chk("t1_ta2", {31'd0, ta2}, 32'd0);
      chk("t1_ta2_oe", {31'd0, ta2_oe}, 32'd1);
      chk("t1_oe_end", {31'd0, mdo_oe}, 32'd0);
      chk("t1_count", wb_count - base, 32'd1);
      chk("t1_we", {31'd0, wb_we}, 32'd0);
      chk("t1_addr", {27'd0, wb_addr}, 32'd1);

      // 2: write
      base = wb_count;
      oe_seen = 1'b0;
      frame(32, 1'b0, PA, 5'd0, 16'h8000, -1, rdat, ta2, ta2_oe);
      chk("t2_count", wb_count - base, 32'd1);
      chk("t2_we", {31'd0, wb_we}, 32'd1);
      chk("t2_addr", {27'd0, wb_addr}, 32'd0);
      chk("t2_dw", {16'd0, wb_dw}, 32'h8000);
      chk("t2_oe", {31'd0, oe_seen}, 32'd0);
      chk("t2_cyc_end", {31'd0, cyc}, 32'd0);

      // 3: other PHY address, then a matching read
      oe_seen = 1'b0;
      cyc_seen = 1'b0;
      frame(32, 1'b1, PA ^ 5'd1, 5'd1, 16'h0, -1, rdat, ta2, ta2_oe);
      chk("t3_cyc", {31'd0, cyc_seen}, 32'd0);
      chk("t3_oe", {31'd0, oe_seen}, 32'd0);
      chk("t3_float", {16'd0, rdat}, 32'hFFFF);
      rd_val = 16'hA5C3;
      frame(32, 1'b1, PA, 5'd2, 16'h0, -1, rdat, ta2, ta2_oe);
      chk("t3_next", {16'd0, rdat}, 32'hA5C3);
      chk("t3_next_addr", {27'd0, wb_addr}, 32'd2);

      // 4: short preamble ignored, full preamble served
      cyc_seen = 1'b0;
      frame(31, 1'b1, PA, 5'd4, 16'h0, -1, rdat, ta2, ta2_oe);
      chk("t4_short", {31'd0, cyc_seen}, 32'd0);
      rd_val = 16'h1C3E;
      base = wb_count;
      frame(32, 1'b1, PA, 5'd4, 16'h0, -1, rdat, ta2, ta2_oe);
      chk("t4_full", {16'd0, rdat}, 32'h1C3E);
      chk("t4_count", wb_count - base, 32'd1);

      // 5: read with slave error
      slv_err = 1'b1;
      oe_seen = 1'b0;
      err_then_cyc = 1'b1;
      base = wb_count;
      frame(32, 1'b1, PA, 5'd5, 16'h0, -1, rdat, ta2, ta2_oe);
      slv_err = 1'b0;
      chk("t5_count", wb_count - base, 32'd1);
      chk("t5_addr", {27'd0, wb_addr}, 32'd5);
      chk("t5_cyc_drop", {31'd0, err_then_cyc}, 32'd0);
      chk("t5_oe", {31'd0, oe_seen}, 32'd0);
      chk("t5_float", {16'd0, rdat}, 32'hFFFF);

      // 6: reset in the middle of read data
      rd_val = 16'h5A5A;
      frame(32, 1'b1, PA, 5'd6, 16'h0, 8, rdat, ta2, ta2_oe);
      chk("t6_oe_before", {31'd0, mdo_oe}, 32'd1);
      @(posedge clk);
      #1;
      chk("t6_oe_rst", {31'd0, mdo_oe}, 32'd0);
      chk("t6_cyc_rst", {31'd0, cyc}, 32'd0);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      rd_val = 16'h1234;
      frame(32, 1'b1, PA, 5'd3, 16'h0, -1, rdat, ta2, ta2_oe);
      chk("t6_after", {16'd0, rdat}, 32'h1234);
      chk("t6_after_addr", {27'd0, wb_addr}, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
